e_md_unit: RTL and testbench
============================

Name: e_md_unit

Overview:
- Multiply/divide unit in the Execute stage, directly downstream of the decode stage.
- Consumes the forwarded rs/rt operands and the MD operation decoded for the instruction in E.
- Owns the HI/LO registers and models the multi-cycle latency of MULT/MULTU/DIV/DIVU.
- Drives Busy to the hazard unit and MDOut to the E-stage result mux for MFHI/MFLO.

Parameters:
MULT_CYCLES, 5, cycles from MULT/MULTU issue until HI/LO are updated (>=1)
DIV_CYCLES, 10, cycles from DIV/DIVU issue until HI/LO are updated (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low (reset==0 clears state on next clk edge)
A  input  32  forwarded rs value (E stage)
B  input  32  forwarded rt value (E stage)
MDOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; others = NONE
Start  output  1  combinational; 1 when MDOp is 1..4 and the op is accepted
Busy  output  1  registered; 1 while a mult/div is in flight
HI  output  32  current HI register
LO  output  32  current LO register
MDOut  output  32  combinational; HI when MDOp==MFHI, LO when MDOp==MFLO, else 0

Behaviour:
- Reset (reset==0 at the clk edge):
  - HI=0, LO=0, Busy=0, counter=0.
  - Any in-flight operation is discarded and never commits.
  - Reset has priority over every other event.
- States:
  - IDLE (Busy=0).
  - RUN (Busy=1, counter counts down).
- Acceptance:
  - In IDLE, an MDOp of 1..4 is accepted: Start=1.
  - Operands are latched on that edge and the exact result is computed from the latched operands.
  - The counter loads MULT_CYCLES or DIV_CYCLES; the unit enters RUN.
- RUN:
  - The counter decrements every cycle.
  - On the edge where the counter goes 1->0: HI/LO commit the pending result, Busy drops to 0, and the unit returns to IDLE on the same edge.
  - With N cycles of latency, Busy is high for exactly N cycles after the issue edge, and the new HI/LO are visible in the cycle Busy is first 0.
- Ops presented while Busy=1:
  - Mult/div ops (1..4) and MTHI/MTLO are ignored. Start=0 and no register changes.
  - The D stage must stall any isMD instruction while (Busy | Start). The ignore rule is a safety net only.
- MFHI/MFLO:
  - Read HI/LO combinationally via MDOut.
  - Never change state.
  - During Busy, MDOut still returns the pre-operation HI/LO.
- MTHI/MTLO (IDLE only): HI<=A or LO<=A on the next edge, with no latency.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Boundaries:
  - Divide by zero (B==0, DIV or DIVU): the op still runs for the full DIV_CYCLES with Busy asserted, but HI/LO stay unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
  - Back-to-back: a new mult/div may be accepted in the cycle immediately after the commit edge.
  - No overlap with the commit edge.

Decomposition:
- Shared package/header `md_defs`:
  - MDOp encodings MD_NONE..MD_MTLO (4-bit).
  - Default latency constants.
  - Shared with the Controller so that isMD and MDOp decoding agree.
- One natural sub-module, `md_compute`: purely combinational, producing a 64-bit result {hi,lo} and a `valid` flag (0 for divide by zero) from the latched operands and op.
- The top level holds the counter/FSM and the HI/LO registers.

Test Plan:
- Reset then idle: reset=0 for 2 cycles -> HI=LO=0, Busy=0. Then MFHI -> MDOut=0.
- MULT A=0xFFFFFFFE(-2), B=3 -> Start=1 for one cycle; Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9(-7), B=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- DIV by zero after MTHI 0x1234 / MTLO 0x5678 -> Busy for 10 cycles; HI=0x1234 and LO=0x5678 unchanged. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- While Busy from a MULT: present MTLO A=0xAAAA and a DIVU -> both ignored (Start=0); MFLO during Busy returns the old LO; after commit, LO = product. Then issue DIVU in the first non-Busy cycle -> accepted.
- Reset mid-operation: assert reset=0 on cycle 3 of a MULT -> Busy=0 and HI=LO=0 next cycle; no later commit occurs.

Source files
------------

// File: rtl/md_defs.sv
// Shared multiply/divide definitions: MDOp encodings, default latencies and op-class helpers.
// The Controller imports this too, so its isMD decoding stays in step with the unit.
package md_defs;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= 4'(MD_MULT)) && (op <= 4'(MD_DIVU));
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == 4'(MD_DIV)) || (op == 4'(MD_DIVU));
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational mult/div datapath: exact 64-bit {hi,lo} result from latched operands.
// Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
module md_compute
  import md_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        valid
);

  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    signed_op = (op == 4'(MD_MULT)) || (op == 4'(MD_DIV));
    a_neg     = signed_op & a[31];
    b_neg     = signed_op & b[31];
    a_mag     = a_neg ? (~a + 32'd1) : a;
    b_mag     = b_neg ? (~b + 32'd1) : b;
    // Divisor forced non-zero so the divider never sees x/0; valid flags the case instead.
    div_b     = (b == 32'd0) ? 32'd1 : b_mag;
    q_mag     = a_mag / div_b;
    r_mag     = a_mag % div_b;
    quot      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem       = a_neg ? (~r_mag + 32'd1) : r_mag;
    result    = '0;
    valid     = 1'b1;
    case (op)
      4'(MD_MULT):  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      4'(MD_MULTU): result = {32'd0, a} * {32'd0, b};
      4'(MD_DIV), 4'(MD_DIVU): begin
        result = {rem, quot};
        valid  = (b != 32'd0);
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/e_md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models mult/div latency with a countdown,
// and serves MFHI/MFLO combinationally.
module e_md_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state;
  md_state_e        state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      hi_next;
  logic [31:0]      lo_next;
  logic [3:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic             accept;
  logic [63:0]      result;
  logic             result_valid;

  md_compute u_compute (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (result),
    .valid  (result_valid)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    hi_next    = hi_q;
    lo_next    = lo_q;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_muldiv(MDOp)) begin
          accept     = 1'b1;
          state_next = ST_RUN;
          count_next = is_div(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (MDOp == 4'(MD_MTHI)) begin
          hi_next = A;
        end else if (MDOp == 4'(MD_MTLO)) begin
          lo_next = A;
        end
      end
      ST_RUN: begin
        count_next = count - CNT_W'(1);
        // Commit on the 1->0 edge; divide-by-zero leaves HI/LO untouched.
        if (count == CNT_W'(1)) begin
          state_next = ST_IDLE;
          if (result_valid) begin
            hi_next = result[63:32];
            lo_next = result[31:0];
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      op_q  <= 4'(MD_NONE);
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      hi_q  <= hi_next;
      lo_q  <= lo_next;
      if (accept) begin
        op_q <= MDOp;
        a_q  <= A;
        b_q  <= B;
      end
    end
  end

  assign Start = accept;
  assign Busy  = (state == ST_RUN);
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign MDOut = (MDOp == 4'(MD_MFHI)) ? hi_q :
                 (MDOp == 4'(MD_MFLO)) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_md_unit.sv
// Bench for e_md_unit: directed scenarios plus a randomized run against a cycle-level model.
module tb_e_md_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3,
                         OP_DIVU = 4'd4, OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7,
                         OP_MTLO = 4'd8;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_cnt;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_res;
  logic        m_valid;

  e_md_unit #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDOp  (MDOp),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO),
    .MDOut (MDOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp = op;
    A    = a;
    B    = b;
  endtask

  // Issues one op, then counts Busy cycles (bounded) until the unit is idle again.
  task automatic issue_and_wait(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic started, output int busy_cycles);
    drive(op, a, b);
    #1;
    started = Start;
    tick();
    drive(OP_NONE, 32'd0, 32'd0);
    busy_cycles = 0;
    while (Busy && busy_cycles < 64) begin
      busy_cycles++;
      tick();
    end
  endtask

  // Expected {valid, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] model_compute(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    logic            ok;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = 64'd0;
    ok  = 1'b1;
    if (op == OP_MULT) begin
      res = 64'(sa * sb);
    end else if (op == OP_MULTU) begin
      res = 64'(ua * ub);
    end else if (b == 32'd0) begin
      ok = 1'b0;
    end else if (op == OP_DIV) begin
      q   = sa / sb;
      r   = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      uq  = ua / ub;
      ur  = ua % ub;
      res = {ur[31:0], uq[31:0]};
    end
    return {ok, res};
  endfunction

  task automatic model_edge(input logic rst_n, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
    logic [64:0] cr;
    if (!rst_n) begin
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0 && m_valid) {m_hi, m_lo} = m_res;
    end else if (op >= OP_MULT && op <= OP_DIVU) begin
      cr      = model_compute(op, a, b);
      m_valid = cr[64];
      m_res   = cr[63:0];
      m_cnt   = (op <= OP_MULTU) ? MULT_LAT : DIV_LAT;
    end else if (op == OP_MTHI) begin
      m_hi = a;
    end else if (op == OP_MTLO) begin
      m_lo = a;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(OP_NONE, 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    checks++; if (HI !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h expected 0", HI); end
    checks++; if (LO !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h expected 0", LO); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    drive(OP_MFHI, 32'd0, 32'd0);
    #1;
    checks++; if (MDOut !== 32'd0) begin failures++; $display("FAIL reset_mfhi: got %h expected 0", MDOut); end
    tick();
  endtask

  task automatic test_mult;
    logic st;
    int   bc;
    issue_and_wait(OP_MULT, 32'hFFFFFFFE, 32'd3, st, bc);
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL mult_start: got %b expected 1", st); end
    checks++; if (bc != MULT_LAT) begin failures++; $display("FAIL mult_busy: got %0d expected %0d", bc, MULT_LAT); end
    checks++; if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFA) begin failures++; $display("FAIL mult_result: got %h_%h expected ffffffff_fffffffa", HI, LO); end
    issue_and_wait(OP_MULTU, 32'hFFFFFFFE, 32'd3, st, bc);
    checks++; if ({HI, LO} !== 64'h00000002_FFFFFFFA) begin failures++; $display("FAIL multu_result: got %h_%h expected 00000002_fffffffa", HI, LO); end
  endtask

  task automatic test_div;
    logic st;
    int   bc;
    issue_and_wait(OP_DIV, 32'hFFFFFFF9, 32'd2, st, bc);
    checks++; if (bc != DIV_LAT) begin failures++; $display("FAIL div_busy: got %0d expected %0d", bc, DIV_LAT); end
    checks++; if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFD) begin failures++; $display("FAIL div_result: got %h_%h expected ffffffff_fffffffd", HI, LO); end
    issue_and_wait(OP_DIVU, 32'd7, 32'd2, st, bc);
    checks++; if ({HI, LO} !== 64'h00000001_00000003) begin failures++; $display("FAIL divu_result: got %h_%h expected 00000001_00000003", HI, LO); end
  endtask

  task automatic test_div_boundaries;
    logic st;
    int   bc;
    drive(OP_MTHI, 32'h1234, 32'd0);
    tick();
    drive(OP_MTLO, 32'h5678, 32'd0);
    tick();
    checks++; if ({HI, LO} !== 64'h00001234_00005678) begin failures++; $display("FAIL mt_write: got %h_%h expected 00001234_00005678", HI, LO); end
    issue_and_wait(OP_DIV, 32'd99, 32'd0, st, bc);
    checks++; if (bc != DIV_LAT) begin failures++; $display("FAIL div0_busy: got %0d expected %0d", bc, DIV_LAT); end
    checks++; if ({HI, LO} !== 64'h00001234_00005678) begin failures++; $display("FAIL div0_keep: got %h_%h expected 00001234_00005678", HI, LO); end
    issue_and_wait(OP_DIV, 32'h80000000, 32'hFFFFFFFF, st, bc);
    checks++; if ({HI, LO} !== 64'h00000000_80000000) begin failures++; $display("FAIL div_ovf: got %h_%h expected 00000000_80000000", HI, LO); end
  endtask

  task automatic test_busy_ignore;
    logic st;
    int   bc;
    drive(OP_MULT, 32'd6, 32'd7);
    tick();
    drive(OP_MTLO, 32'hAAAA, 32'd0);
    #1;
    checks++; if (Start !== 1'b0) begin failures++; $display("FAIL busy_mtlo_start: got %b expected 0", Start); end
    tick();
    drive(OP_DIVU, 32'd100, 32'd3);
    #1;
    checks++; if (Start !== 1'b0) begin failures++; $display("FAIL busy_divu_start: got %b expected 0", Start); end
    tick();
    drive(OP_MFLO, 32'd0, 32'd0);
    #1;
    checks++; if (MDOut !== 32'h80000000) begin failures++; $display("FAIL busy_mflo: got %h expected 80000000", MDOut); end
    checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL busy_flag: got %b expected 1", Busy); end
    bc = 0;
    while (Busy && bc < 64) begin
      bc++;
      tick();
    end
    checks++; if (bc != MULT_LAT - 2) begin failures++; $display("FAIL busy_remaining: got %0d expected %0d", bc, MULT_LAT - 2); end
    checks++; if ({HI, LO} !== 64'h00000000_0000002A) begin failures++; $display("FAIL busy_commit: got %h_%h expected 00000000_0000002a", HI, LO); end
    // Back-to-back: first non-Busy cycle must accept
    issue_and_wait(OP_DIVU, 32'd100, 32'd3, st, bc);
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL b2b_start: got %b expected 1", st); end
    checks++; if ({HI, LO} !== 64'h00000001_00000021) begin failures++; $display("FAIL b2b_result: got %h_%h expected 00000001_00000021", HI, LO); end
  endtask

  task automatic test_reset_mid;
    drive(OP_MULT, 32'd5, 32'd5);
    tick();
    drive(OP_NONE, 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", Busy); end
    checks++; if ({HI, LO} !== 64'd0) begin failures++; $display("FAIL midrst_regs: got %h_%h expected 0", HI, LO); end
    for (int i = 0; i < 8; i++) tick();
    checks++; if ({HI, LO} !== 64'd0) begin failures++; $display("FAIL midrst_nocommit: got %h_%h expected 0", HI, LO); end
  endtask

  task automatic test_random;
    logic        rst_n;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_start;
    reset = 1'b0;
    drive(OP_NONE, 32'd0, 32'd0);
    tick();
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0; m_cnt = 0; m_res = 64'd0; m_valid = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      op    = 4'($urandom_range(0, 11));
      a     = $urandom();
      b     = $urandom();
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      drive(op, a, b);
      reset = rst_n;
      #1;
      exp_start = (m_cnt == 0) && (op >= OP_MULT) && (op <= OP_DIVU);
      exp_out   = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
      checks++; if (Busy !== (m_cnt > 0)) begin failures++; $display("FAIL rnd_busy[%0d]: got %b expected %b", i, Busy, m_cnt > 0); end
      checks++; if (HI !== m_hi) begin failures++; $display("FAIL rnd_hi[%0d]: got %h expected %h", i, HI, m_hi); end
      checks++; if (LO !== m_lo) begin failures++; $display("FAIL rnd_lo[%0d]: got %h expected %h", i, LO, m_lo); end
      checks++; if (MDOut !== exp_out) begin failures++; $display("FAIL rnd_mdout[%0d]: got %h expected %h", i, MDOut, exp_out); end
      if (rst_n) begin
        checks++; if (Start !== exp_start) begin failures++; $display("FAIL rnd_start[%0d]: got %b expected %b", i, Start, exp_start); end
      end
      tick();
      model_edge(rst_n, op, a, b);
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(OP_NONE, 32'd0, 32'd0);
    test_reset();
    test_mult();
    test_div();
    test_div_boundaries();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
